// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg: shared opcodes, queue entry layout and FSM state type for the fetch queue
package fetch_queue_unit_pkg;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam int          SIZE_W     = 2;
    localparam int          PC_W       = 32;
    localparam logic [31:0] NOP_INST   = 32'h00000013;
    typedef enum logic [SIZE_W-1:0] {CS_BYTE, CS_HALF, CS_WORD} cs_size;
    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic            err;
    } fq_entry_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN, ST_HALT} fq_state_e;
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus bundle between one master and one slave
//   master drives psel/penable/pwrite/paddr/pwdata; slave drives prdata/pready/pslverr
interface apb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_controller_sbm.sv
// apb_controller_sbm: single-transfer APB master; start_i opens the setup phase combinationally
//   in : clk, rst_n, start_i, dir_i (1=write), addr_i, wdata_i
//   out: done_o (transfer completed this cycle), err_o (completed with PSLVERR), rdata_o
//   apb: apb_if.master
module apb_controller_sbm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    apb_if.master             apb
);
    logic              r_access;
    logic              r_dir;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_access <= 1'b0;
            r_dir    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (!r_access && start_i) begin
            r_access <= 1'b1;
            r_dir    <= dir_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
        end else if (r_access && apb.pready) begin
            r_access <= 1'b0;
        end
    end
    // Setup phase is driven straight from the request so a transfer costs only two cycles.
    assign apb.psel    = r_access | start_i;
    assign apb.penable = r_access;
    assign apb.pwrite  = r_access ? r_dir : dir_i;
    assign apb.paddr   = r_access ? r_addr : addr_i;
    assign apb.pwdata  = r_access ? r_wdata : wdata_i;
    assign done_o      = r_access & apb.pready;
    assign err_o       = done_o & apb.pslverr;
    assign rdata_o     = apb.prdata;
endmodule

// File: rtl/fq_fifo_sbm.sv
// fq_fifo_sbm: first-word-fall-through FIFO of fetch entries with synchronous clear
//   in : clk, rst_n, clear_i (wins over push/pop), push_i, pop_i, din_i
//   out: dout_o (head, zero when empty), count_o
module fq_fifo_sbm import fetch_queue_unit_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  fq_entry_t                    din_i,
    output fq_entry_t                    dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    assign w_push = push_i && r_count != CNT_W'(DEPTH);
    assign w_pop  = pop_i && r_count != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (clear_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PTR_W'(w_push);
            r_rd    <= r_rd + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !clear_i) r_mem[r_wr] <= din_i;
    end
    assign dout_o  = r_count != '0 ? r_mem[r_rd] : '0;
    assign count_o = r_count;
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && r_count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: prefetching IF stage with static branch prediction feeding ID from a small queue
//   in : clk, rst_n, flush_i/flush_pc_i (redirect), ready_i (ID takes head)
//   out: valid_o, inst_o, pc_o, pred_taken_o, fetch_err_o, count_o
//   apb: imem_apb (read-only instruction fetch)
module fetch_queue_unit import fetch_queue_unit_pkg::*; #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] INIT_PC = '0,
    parameter int                DEPTH   = 4,
    parameter bit                PREDICT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    apb_if.master                        imem_apb,
    input  logic                         flush_i,
    input  logic [ADDR_W-1:0]            flush_pc_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [31:0]                  inst_o,
    output logic [ADDR_W-1:0]            pc_o,
    output logic                         pred_taken_o,
    output logic                         fetch_err_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CNT_W = $clog2(DEPTH+1);
    fq_state_e         r_state;
    fq_state_e         w_state_nx;
    logic [ADDR_W-1:0] r_pc_fetch;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [ADDR_W-1:0] w_next_pc;
    logic [31:0]       w_rdata;
    logic [31:0]       w_jimm;
    logic [31:0]       w_bimm;
    logic              w_is_jal;
    logic              w_is_bt;
    logic              w_start;
    logic              w_push;
    logic              w_done;
    logic              w_err;
    logic              w_credit;
    fq_entry_t         w_din;
    fq_entry_t         w_head;
    apb_controller_sbm #(.ADDR_W(ADDR_W), .DATA_W(32)) u_apb (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (w_start),
        .dir_i   (1'b0),
        .addr_i  (r_pc_fetch),
        .wdata_i (32'h0),
        .done_o  (w_done),
        .err_o   (w_err),
        .rdata_o (w_rdata),
        .apb     (imem_apb)
    );
    fq_fifo_sbm #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush_i),
        .push_i  (w_push),
        .pop_i   (valid_o & ready_i),
        .din_i   (w_din),
        .dout_o  (w_head),
        .count_o (count_o)
    );
    assign w_jimm    = {{12{w_rdata[31]}}, w_rdata[19:12], w_rdata[20], w_rdata[30:21], 1'b0};
    assign w_bimm    = {{20{w_rdata[31]}}, w_rdata[7], w_rdata[30:25], w_rdata[11:8], 1'b0};
    assign w_is_jal  = PREDICT && w_rdata[6:0] == OPC_JAL;
    assign w_is_bt   = PREDICT && w_rdata[6:0] == OPC_BRANCH && w_rdata[31];
    assign w_next_pc = r_pc_fetch + (w_is_jal ? ADDR_W'($signed(w_jimm)) :
                                     w_is_bt  ? ADDR_W'($signed(w_bimm)) : ADDR_W'(4));
    // Counting the in-flight fetch guarantees its response always finds a free slot.
    assign w_credit  = ({1'b0, count_o} + (CNT_W+1)'(r_state == ST_WAIT)) < (CNT_W+1)'(DEPTH);
    assign w_din     = w_err ? fq_entry_t'{NOP_INST, PC_W'(r_pc_fetch), 1'b0, 1'b1}
                             : fq_entry_t'{w_rdata, PC_W'(r_pc_fetch), w_is_jal | w_is_bt, 1'b0};
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc_fetch;
        w_start    = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start    = w_credit & !flush_i;
                w_state_nx = w_start ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_push     = !flush_i;
                    w_state_nx = (w_err && !flush_i) ? ST_HALT : ST_IDLE;
                    w_pc_nx    = w_err ? r_pc_fetch : w_next_pc;
                end else if (flush_i) begin
                    w_state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_nx = w_done ? ST_IDLE : ST_DRAIN;
            ST_HALT:  w_state_nx = flush_i ? ST_IDLE : ST_HALT;
            default:  w_state_nx = ST_IDLE;
        endcase
        if (flush_i) w_pc_nx = flush_pc_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc_fetch <= INIT_PC;
        end else begin
            r_state    <= w_state_nx;
            r_pc_fetch <= w_pc_nx;
        end
    end
    assign valid_o      = count_o != '0;
    assign inst_o       = w_head.inst;
    assign pc_o         = ADDR_W'(w_head.pc);
    assign pred_taken_o = w_head.pred_taken;
    assign fetch_err_o  = w_head.err;
    assert property (@(posedge clk) disable iff (!rst_n) count_o <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) valid_o == (count_o != '0));
    assert property (@(posedge clk) disable iff (!rst_n) r_state == ST_HALT |-> !imem_apb.psel);
    assert property (@(posedge clk) disable iff (!rst_n) r_state == ST_DRAIN |-> !(imem_apb.psel && !imem_apb.penable));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: random fetch/flush/error traffic against a transaction-level queue model
module tb_fetch_queue_unit;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] INIT_PC = 32'h100;
    localparam logic [31:0] NOP     = 32'h13;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic        err;
    } exp_t;
    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        flush_i    = 1'b0;
    logic        ready_i    = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        valid_o;
    logic        pred_taken_o;
    logic        fetch_err_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [2:0]  count_o;
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus();
    fetch_queue_unit #(.ADDR_W(32), .INIT_PC(INIT_PC), .DEPTH(DEPTH), .PREDICT(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_apb     (bus),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .pred_taken_o (pred_taken_o),
        .fetch_err_o  (fetch_err_o),
        .count_o      (count_o)
    );
    always #5 clk = ~clk;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        m_q[$];
    logic [31:0] m_pc = INIT_PC;
    bit          m_inflight = 0;
    bit          m_discard = 0;
    bit          m_halt = 0;
    logic [31:0] s_inst = '0;
    logic [31:0] s_next = '0;
    bit          s_pred = 0;
    bit          s_err = 0;
    int          s_wait = 0;
    int          p_ready, p_flush, p_err, max_wait;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask
    function automatic logic [31:0] enc_jal(input logic [31:0] u);
        return {u[20], u[10:1], u[11], u[19:12], 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_br(input logic [31:0] u);
        return {u[12], u[10:5], 5'd2, 5'd3, 3'b000, u[4:1], u[11], 7'b1100011};
    endfunction
    task automatic new_xfer();
        int          kind;
        logic [31:0] imm;
        logic [31:0] r;
        kind   = $urandom_range(0, 3);
        r      = $urandom();
        s_wait = $urandom_range(0, max_wait);
        s_err  = $urandom_range(0, 99) < p_err;
        s_pred = 0;
        s_next = m_pc + 32'd4;
        case (kind)
            0: begin
                imm    = 2 * $urandom_range(0, (1 << 20) - 1) - (1 << 20);
                s_inst = enc_jal(imm);
                s_pred = 1;
                s_next = m_pc + imm;
            end
            1: begin
                imm    = 2 * $urandom_range(0, 4095) - 4096;
                s_inst = enc_br(imm);
                if ($signed(imm) < 0) begin
                    s_pred = 1;
                    s_next = m_pc + imm;
                end
            end
            2: s_inst = {r[31:7], 7'b0010011};
            default: s_inst = {r[31:15], 3'b000, r[11:7], 7'b1100111};
        endcase
    endtask
    task automatic cycle();
        bit setup, done, pop, exp_issue;
        flush_i     = $urandom_range(0, 99) < p_flush;
        flush_pc_i  = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : ($urandom() & 32'hFFFF_FFFC);
        ready_i     = $urandom_range(0, 99) < p_ready;
        bus.pready  = bus.penable ? (s_wait == 0) : 1'($urandom_range(0, 1));
        bus.prdata  = s_inst;
        bus.pslverr = s_err;
        #1;
        setup     = bus.psel && !bus.penable;
        done      = bus.penable && bus.pready;
        exp_issue = !flush_i && !m_inflight && !m_halt && m_q.size() < DEPTH;
        chk("count", 64'(count_o), 64'(m_q.size()));
        chk("valid", 64'(valid_o), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("head_inst", 64'(inst_o), 64'(m_q[0].inst));
            chk("head_pc", 64'(pc_o), 64'(m_q[0].pc));
            chk("head_pred", 64'(pred_taken_o), 64'(m_q[0].pred));
            chk("head_err", 64'(fetch_err_o), 64'(m_q[0].err));
        end
        chk("issue", 64'(setup), 64'(exp_issue));
        if (setup) begin
            chk("paddr", 64'(bus.paddr), 64'(m_pc));
            chk("pwrite", 64'(bus.pwrite), 64'(1'b0));
        end
        pop = m_q.size() != 0 && ready_i;
        if (bus.penable && !bus.pready) s_wait--;
        if (flush_i) begin
            m_q.delete();
            m_pc   = flush_pc_i;
            m_halt = 0;
            if (done) begin
                m_inflight = 0;
                m_discard  = 0;
            end else if (m_inflight) begin
                m_discard = 1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (done) begin
                if (m_inflight && !m_discard) begin
                    if (s_err) begin
                        m_q.push_back(exp_t'{NOP, m_pc, 1'b0, 1'b1});
                        m_halt = 1;
                    end else begin
                        m_q.push_back(exp_t'{s_inst, m_pc, s_pred, 1'b0});
                        m_pc = s_next;
                    end
                end
                m_inflight = 0;
                m_discard  = 0;
            end
            if (setup) m_inflight = 1;
        end
        if (setup) new_xfer();
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        ready_i     = 1'b0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        #1;
        chk("rst_valid", 64'(valid_o), 64'(1'b0));
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_inst", 64'(inst_o), 64'(0));
        chk("rst_pc", 64'(pc_o), 64'(0));
        chk("rst_pred", 64'(pred_taken_o), 64'(1'b0));
        chk("rst_err", 64'(fetch_err_o), 64'(1'b0));
        chk("rst_penable", 64'(bus.penable), 64'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_pc       = INIT_PC;
        m_inflight = 0;
        m_discard  = 0;
        m_halt     = 0;
        s_wait     = 0;
    endtask
    task automatic phase(input int n, input int pr, input int pf, input int pe, input int mw);
        p_ready  = pr;
        p_flush  = pf;
        p_err    = pe;
        max_wait = mw;
        repeat (n) cycle();
    endtask
    initial begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        p_ready = 100; p_flush = 0; p_err = 0; max_wait = 0;
        @(negedge clk);
        do_reset();
        phase(200, 100, 0, 0, 0);
        phase(150, 5, 0, 0, 0);
        phase(400, 60, 5, 0, 3);
        do_reset();
        phase(400, 70, 6, 8, 2);
        phase(400, 40, 15, 5, 3);
        phase(200, 90, 2, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
